// File: rtl/rr_bus_arbiter16_if.sv
// Request/grant bundle between the 16 requesters and the round-robin arbiter.
interface rr_bus_arbiter16_if;
  logic        en;
  logic [15:0] req;
  logic        last;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic [3:0]  sel;
  logic        timeout;

  modport master (
    output en, req, last,
    input  gnt, gnt_valid, sel, timeout
  );

  modport slave (
    input  en, req, last,
    output gnt, gnt_valid, sel, timeout
  );
endinterface

// File: rtl/rr_bus_arbiter16.sv
// Tenure-based round-robin arbiter sharing one mux16_1 datapath between
// 16 requesters. A one-cycle turnaround separates tenures so the registered
// mux select never moves while a grant is active.
module rr_bus_arbiter16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic               clk,
  input logic               rst,
  rr_bus_arbiter16_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam int unsigned HOLD_LIM  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [7:0]  HOLD_LAST = HOLD_LIM[7:0];

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] gnt_n;
  logic        valid_n;
  logic [3:0]  sel_n;
  logic        to_n;

  logic [3:0]  win;
  logic        found;
  logic [3:0]  scan_idx;

  logic        by_last, by_drop, by_limit, tenure_end;

  // Rotating priority scan: first requester at or after ptr, wrapping mod 16.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      scan_idx = ptr + k[3:0];
      if (!found && bus.req[scan_idx]) begin
        win   = scan_idx;
        found = 1'b1;
      end
    end
  end

  // Tenure end causes; the owner index is always the registered sel.
  always_comb begin
    by_last    = bus.last;
    by_drop    = !bus.req[bus.sel];
    by_limit   = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    tenure_end = by_last || by_drop || by_limit;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = bus.gnt;
    valid_n = bus.gnt_valid;
    sel_n   = bus.sel;
    to_n    = 1'b0;
    case (state)
      IDLE, TURN: begin
        if (bus.en && found) begin
          state_n = GRANT;
          gnt_n   = 16'(1) << win;
          valid_n = 1'b1;
          sel_n   = win;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          valid_n = 1'b0;
        end
      end
      GRANT: begin
        if (tenure_end) begin
          state_n = TURN;
          gnt_n   = '0;
          valid_n = 1'b0;
          ptr_n   = bus.sel + 4'd1;
          to_n    = by_limit && !by_last && !by_drop;
        end else if (cnt != '1) begin
          // Saturate so an unlimited tenure never wraps the counter.
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      bus.gnt       <= '0;
      bus.gnt_valid <= 1'b0;
      bus.sel       <= '0;
      bus.timeout   <= 1'b0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      cnt           <= cnt_n;
      bus.gnt       <= gnt_n;
      bus.gnt_valid <= valid_n;
      bus.sel       <= sel_n;
      bus.timeout   <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter16.sv
// Bench for rr_bus_arbiter16: three instances (MAX_HOLD 4, 0, 8) share one
// stimulus stream and are each compared against a tenure-level model.
module tb_rr_bus_arbiter16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_s = 1'b0;
  logic [15:0] req_s = '0;
  logic        last_s = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter16_if if_h4();
  rr_bus_arbiter16_if if_h0();
  rr_bus_arbiter16_if if_h8();

  assign if_h4.en = en_s;  assign if_h4.req = req_s;  assign if_h4.last = last_s;
  assign if_h0.en = en_s;  assign if_h0.req = req_s;  assign if_h0.last = last_s;
  assign if_h8.en = en_s;  assign if_h8.req = req_s;  assign if_h8.last = last_s;

  rr_bus_arbiter16 #(.MAX_HOLD(4)) u_h4 (.clk(clk), .rst(rst), .bus(if_h4));
  rr_bus_arbiter16 #(.MAX_HOLD(0)) u_h0 (.clk(clk), .rst(rst), .bus(if_h0));
  rr_bus_arbiter16                 u_h8 (.clk(clk), .rst(rst), .bus(if_h8));

  logic [15:0] d_gnt [3];
  logic        d_val [3];
  logic [3:0]  d_sel [3];
  logic        d_to  [3];

  assign d_gnt[0] = if_h4.gnt;  assign d_val[0] = if_h4.gnt_valid;
  assign d_sel[0] = if_h4.sel;  assign d_to[0]  = if_h4.timeout;
  assign d_gnt[1] = if_h0.gnt;  assign d_val[1] = if_h0.gnt_valid;
  assign d_sel[1] = if_h0.sel;  assign d_to[1]  = if_h0.timeout;
  assign d_gnt[2] = if_h8.gnt;  assign d_val[2] = if_h8.gnt_valid;
  assign d_sel[2] = if_h8.sel;  assign d_to[2]  = if_h8.timeout;

  // Tenure-level model: an owner (or none), how many cycles it has held
  // the grant, the priority pointer, the last select and the timeout pulse.
  int HOLD [3] = '{4, 0, 8};
  int m_owner [3];
  int m_held  [3];
  int m_ptr   [3];
  int m_sel   [3];
  bit m_to    [3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1; m_held[i] = 0; m_ptr[i] = 0; m_sel[i] = 0; m_to[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      m_to[i] = 1'b0;
      if (m_owner[i] < 0) begin
        if (en_s && req_s != 16'h0) begin
          for (int k = 0; k < 16; k++) begin
            int j;
            j = (m_ptr[i] + k) % 16;
            if (m_owner[i] < 0 && req_s[j]) m_owner[i] = j;
          end
          m_held[i] = 1;
          m_sel[i]  = m_owner[i];
        end
      end else begin
        bit hit_limit, dropped;
        hit_limit = (HOLD[i] != 0) && (m_held[i] == HOLD[i]);
        dropped   = !req_s[m_owner[i]];
        if (last_s || dropped || hit_limit) begin
          m_to[i]    = hit_limit && !last_s && !dropped;
          m_ptr[i]   = (m_owner[i] + 1) % 16;
          m_owner[i] = -1;
        end else begin
          m_held[i]++;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t: got %h expected %h", name, inst, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] eg;
      eg = (m_owner[i] >= 0) ? (32'd1 << m_owner[i]) : 32'd0;
      chk("model_gnt", i, {16'h0, d_gnt[i]}, eg);
      chk("model_valid", i, {31'h0, d_val[i]}, {31'h0, m_owner[i] >= 0});
      chk("model_sel", i, {28'h0, d_sel[i]}, 32'(m_sel[i]));
      chk("model_timeout", i, {31'h0, d_to[i]}, {31'h0, m_to[i]});
    end
  endtask

  task automatic expect_out(input string name, input int inst, input logic [15:0] g,
                            input logic v, input logic [3:0] s, input logic t);
    chk({name, "_gnt"}, inst, {16'h0, d_gnt[inst]}, {16'h0, g});
    chk({name, "_valid"}, inst, {31'h0, d_val[inst]}, {31'h0, v});
    chk({name, "_sel"}, inst, {28'h0, d_sel[inst]}, {28'h0, s});
    chk({name, "_timeout"}, inst, {31'h0, d_to[inst]}, {31'h0, t});
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; en_s = 1'b0; req_s = '0; last_s = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic        last;
    logic [15:0] gnt;
    logic        val;
    logic [3:0]  sel;
    logic        to;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [15:0] g, input logic v, input logic [3:0] s,
                              input logic t);
    vec_t r;
    r.en = 1'b1; r.req = 16'h8101; r.last = 1'b0;
    r.gnt = g; r.val = v; r.sel = s; r.to = t;
    return r;
  endfunction

  initial begin
    // Rotation on the MAX_HOLD=4 instance with req=0x8101 constant.
    tbl[0]  = mk(16'h0001, 1, 4'd0,  0);
    tbl[1]  = mk(16'h0001, 1, 4'd0,  0);
    tbl[2]  = mk(16'h0001, 1, 4'd0,  0);
    tbl[3]  = mk(16'h0001, 1, 4'd0,  0);
    tbl[4]  = mk(16'h0000, 0, 4'd0,  1);
    tbl[5]  = mk(16'h0100, 1, 4'd8,  0);
    tbl[6]  = mk(16'h0100, 1, 4'd8,  0);
    tbl[7]  = mk(16'h0100, 1, 4'd8,  0);
    tbl[8]  = mk(16'h0100, 1, 4'd8,  0);
    tbl[9]  = mk(16'h0000, 0, 4'd8,  1);
    tbl[10] = mk(16'h8000, 1, 4'd15, 0);
    tbl[11] = mk(16'h8000, 1, 4'd15, 0);
    tbl[12] = mk(16'h8000, 1, 4'd15, 0);
    tbl[13] = mk(16'h8000, 1, 4'd15, 0);
    tbl[14] = mk(16'h0000, 0, 4'd15, 1);
    tbl[15] = mk(16'h0001, 1, 4'd0,  0);

    model_reset();
    #1;
    for (int i = 0; i < 3; i++) expect_out("reset", i, 16'h0, 0, 4'd0, 0);
    do_reset();

    for (int v = 0; v < 16; v++) begin
      en_s = tbl[v].en; req_s = tbl[v].req; last_s = tbl[v].last;
      step();
      expect_out("rotate", 0, tbl[v].gnt, tbl[v].val, tbl[v].sel, tbl[v].to);
    end

    // Single requester, last on the third grant cycle, then re-grant.
    do_reset();
    en_s = 1'b1; req_s = 16'h0020;
    repeat (3) begin
      step();
      expect_out("single_hold", 2, 16'h0020, 1, 4'd5, 0);
    end
    last_s = 1'b1;
    step();
    expect_out("single_turn", 2, 16'h0000, 0, 4'd5, 0);
    last_s = 1'b0;
    step();
    expect_out("single_regrant", 2, 16'h0020, 1, 4'd5, 0);

    // Owner 15 drops its request; pointer wraps to 0.
    do_reset();
    en_s = 1'b1; req_s = 16'h8000;
    step();
    req_s = 16'h8001;
    step();
    req_s = 16'h0001;
    step();
    for (int i = 0; i < 3; i++) expect_out("wrap_turn", i, 16'h0000, 0, 4'd15, 0);
    step();
    for (int i = 0; i < 3; i++) expect_out("wrap_grant", i, 16'h0001, 1, 4'd0, 0);

    // Coincident last and hold limit, then en=0 mid-tenure.
    do_reset();
    en_s = 1'b1; req_s = 16'h0004;
    repeat (4) step();
    last_s = 1'b1;
    step();
    expect_out("coincide", 0, 16'h0000, 0, 4'd2, 0);
    last_s = 1'b0;
    step();
    expect_out("coincide_regrant", 0, 16'h0004, 1, 4'd2, 0);
    en_s = 1'b0;
    repeat (3) begin
      step();
      expect_out("en_off_hold", 0, 16'h0004, 1, 4'd2, 0);
    end
    step();
    expect_out("en_off_timeout", 0, 16'h0000, 0, 4'd2, 1);
    repeat (5) begin
      step();
      expect_out("en_off_blocked", 0, 16'h0000, 0, 4'd2, 0);
    end
    en_s = 1'b1;
    step();
    expect_out("en_on_grant", 0, 16'h0004, 1, 4'd2, 0);

    // Unlimited hold on the MAX_HOLD=0 instance.
    do_reset();
    en_s = 1'b1; req_s = 16'h0003;
    repeat (300) begin
      step();
      expect_out("unlimited", 1, 16'h0001, 1, 4'd0, 0);
    end
    req_s = 16'h0002;
    step();
    expect_out("unlimited_turn", 1, 16'h0000, 0, 4'd0, 0);
    step();
    expect_out("unlimited_next", 1, 16'h0002, 1, 4'd1, 0);

    // Asynchronous reset in the middle of a tenure.
    req_s = 16'hFFFF;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) expect_out("async_reset", i, 16'h0, 0, 4'd0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; req_s = '0;
    repeat (4) begin
      step();
      expect_out("idle_after_reset", 1, 16'h0, 0, 4'd0, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req_s = 16'($urandom & $urandom);
      last_s = ($urandom_range(0, 5) == 0);
      en_s   = ($urandom_range(0, 7) != 0);
      rst    = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter16.md
Name: rr_bus_arbiter16

Overview:
- Round-robin arbiter/scheduler that shares one 32-bit mux16_1 datapath between 16 requesters.
- Produces the registered 4-bit select that drives mux16_1 `sel`, plus a one-hot grant and a valid flag back to the requesters.
- Grants are tenure-based: the owner keeps the resource until it signals last, drops its request, or exceeds a hold limit.
- A one-cycle turnaround separates tenures so the mux select never changes while a grant is active.

Parameters:
- MAX_HOLD, 8: maximum tenure length in cycles; 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; 0 blocks new grants only.
- req  input  16  request vector; bit i = requester i.
- last  input  1  current owner's final transfer is this cycle.
- gnt  output  16  one-hot grant, registered.
- gnt_valid  output  1  a grant is active, registered.
- sel  output  4  index of owner, drives mux16_1 sel, registered.
- timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD.

Behaviour:
- Reset (async, immediate, including mid-tenure): state=IDLE, gnt=0, gnt_valid=0, sel=0, timeout=0, ptr=0, cnt=0.
- ptr (4-bit) is the highest-priority index.
- Winner = first i with req[i]=1, scanning ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16).
- IDLE:
  - If en=1 and |req: load owner=winner, gnt=1<<winner, sel=winner, gnt_valid=1, cnt=0, go to GRANT.
  - Latency is 1 cycle from the req sample to gnt.
  - Otherwise stay in IDLE.
- GRANT, evaluated each cycle. Exit to TURN if any of the following holds:
  - (a) last=1
  - (b) req[owner]=0
  - (c) MAX_HOLD!=0 and cnt==MAX_HOLD-1
- GRANT exit actions:
  - On exit: gnt=0, gnt_valid=0 next cycle, ptr=owner+1 (15 wraps to 0).
  - Otherwise cnt++ and the grant holds.
  - With MAX_HOLD=N, an owner holds gnt for at most N cycles.
- timeout: asserted in the cycle after exit only when (c) is the sole cause. If (a) or (b) coincides with (c), timeout=0.
- TURN:
  - gnt=0, gnt_valid=0, sel holds the previous owner (no select glitch).
  - Arbitrates exactly like IDLE using the updated ptr, so the minimum gap between tenures is 1 cycle.
  - If there is no request or en=0, go to IDLE.
- sel changes only on a new grant load. It holds its value in IDLE and TURN.
- en=0 during GRANT does not affect the current tenure.
- req changes on non-owner bits during GRANT are ignored until TURN.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt[sel]=1.
- cnt width is 8 bits. cnt is cleared on each grant load.

Test Plan:
- Reset: assert rst with req=0xFFFF mid-tenure → gnt=0, gnt_valid=0, sel=0, timeout=0 in the same cycle. After release with req=0, the block stays IDLE.
- Single requester: req=0x0020 held, last=1 on the 3rd grant cycle → gnt=0x0020, sel=5 starting 1 cycle after req, lasting exactly 3 cycles, then 1 TURN cycle, then re-granted to 5 (sole requester), timeout never asserted.
- Rotation with MAX_HOLD=4: req=0x8101 constant, last=0 → grant order 0, 8, 15, 0. Each tenure lasts 4 cycles, each is followed by a timeout pulse and a 1-cycle gap. sel sequence is 0, 8, 15, 0.
- Wrap and drop: owner 15 drops req[15] after 2 cycles with req=0x8001 → TURN, then gnt=0x0001 (ptr wrapped to 0), and timeout=0.
- Coincident causes: MAX_HOLD=4, last=1 on the 4th grant cycle → tenure ends with timeout=0. en=0 asserted mid-tenure → the current tenure completes and no new grant is issued while en=0.
- Unlimited hold: MAX_HOLD=0, req=0x0003 held for 300 cycles with last=0 → requester 0 keeps gnt for all 300 cycles with no timeout (cnt saturation does not cause an exit). Requester 1 is granted only after req[0] drops.
